// File: rtl/fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// fir_mac_sequencer
//
// Produces one FIR output for each accepted input sample. It uses a delay-line
// RAM (a circular buffer of the last NTAPS samples) and a coefficient RAM,
// and both RAMs are shared with the rest of the filter.
//
// Sequence of operation:
//   - After reset, the delay line is cleared to zero.
//   - When coef_loaded is high, the block accepts one sample.
//   - The accepted sample is written at the write pointer.
//   - Every tap is then walked, with one read address pair per cycle.
//   - The MAC enable/clear strobes are issued in step with the read data.
//
// Both RAMs have a one-cycle read latency, so the MAC strobes trail the
// addresses by one cycle.
//
// Handshake: a sample transfers on the rising edge where in_valid && in_ready.
//   - in_ready is high only in IDLE, and only while coef_loaded is high.
//   - Upstream holds in_valid and its data until the transfer.
//   - Upstream keeps the data stable through the following WRITE cycle,
//     because the data goes straight into the delay-line RAM.
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   coef_loaded     coefficient RAM ready; gates acceptance only
//   in_valid        upstream sample available
//   in_ready        sample can be accepted this cycle
//   sample_we       delay-line RAM write enable
//   zero_data       write 0 instead of the upstream sample (clear phase)
//   sample_waddr    delay-line write address
//   sample_raddr    delay-line read address
//   coef_addr       coefficient RAM read address
//   mac_en          MAC consumes the RAM read data this cycle
//   mac_clr         with mac_en: load the product instead of accumulating
//   out_valid       one-cycle pulse, the accumulator holds a finished output
//   dbg_state       current FSM state encoding (observation only)
// -----------------------------------------------------------------------------
module fir_mac_sequencer #(
  parameter int NTAPS = 62,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          coef_loaded,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          sample_we,
  output logic          zero_data,
  output logic [AW-1:0] sample_waddr,
  output logic [AW-1:0] sample_raddr,
  output logic [AW-1:0] coef_addr,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          out_valid,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_CLEAR = 3'd1,
    S_IDLE  = 3'd2,
    S_WRITE = 3'd3,
    S_MAC   = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);
  localparam logic [AW-1:0] K_ONE  = AW'(1);
  localparam logic [AW-1:0] N_MOD  = AW'(NTAPS);

  state_t        r_state;
  logic [AW-1:0] r_k;
  logic [AW-1:0] r_wptr;
  logic          r_mac_en_d;

  logic [AW-1:0] w_diff;
  logic [AW-1:0] w_raddr;

  // Read address of tap k is wptr-k, wrapped into 0..NTAPS-1.
  // The result always lies in 0..NTAPS-1, so the sum fits in AW bits.
  // Adding NTAPS modulo 2^AW in the wrap case therefore gives the same
  // value as the wider form wptr+NTAPS-k.
  assign w_diff  = r_wptr - r_k;
  assign w_raddr = (r_wptr >= r_k) ? w_diff : (w_diff + N_MOD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_k        <= '0;
      r_wptr     <= '0;
      r_mac_en_d <= 1'b0;
    end else begin
      // One cycle behind the tap addresses, matching the RAM read latency.
      r_mac_en_d <= (r_state == S_MAC);
      case (r_state)
        S_INIT: begin
          r_k     <= '0;
          r_state <= S_CLEAR;
        end
        S_CLEAR: begin
          if (r_k == K_LAST) begin
            r_k     <= '0;
            r_state <= S_IDLE;
          end else begin
            r_k <= r_k + K_ONE;
          end
        end
        S_IDLE: begin
          if (in_valid && coef_loaded) begin
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_k     <= '0;
          r_state <= S_MAC;
        end
        S_MAC: begin
          if (r_k == K_LAST) begin
            r_state <= S_DRAIN;
          end else begin
            r_k <= r_k + K_ONE;
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_wptr  <= (r_wptr == K_LAST) ? '0 : (r_wptr + K_ONE);
          r_state <= S_IDLE;
        end
        default: begin
          r_k     <= '0;
          r_state <= S_INIT;
        end
      endcase
    end
  end

  always_comb begin
    in_ready     = 1'b0;
    sample_we    = 1'b0;
    zero_data    = 1'b0;
    sample_waddr = '0;
    sample_raddr = '0;
    coef_addr    = '0;
    out_valid    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        sample_we    = 1'b1;
        zero_data    = 1'b1;
        sample_waddr = r_k;
      end
      S_IDLE: begin
        in_ready = coef_loaded;
      end
      S_WRITE: begin
        sample_we    = 1'b1;
        sample_waddr = r_wptr;
      end
      S_MAC: begin
        coef_addr    = r_k;
        sample_raddr = w_raddr;
      end
      S_DONE: begin
        out_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Tap 0 data arrives while the FSM is presenting tap 1 (NTAPS >= 2).
  assign mac_en    = r_mac_en_d;
  assign mac_clr   = r_mac_en_d && (r_state == S_MAC) && (r_k == K_ONE);
  assign dbg_state = r_state;

endmodule
